// File: rtl/cprv_mem_arbiter_if.sv
// Handshake bundle between the two CPU requesters (fetch, data), the arbiter,
// and the shared single-port RAM.
interface cprv_mem_arbiter_if #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 7
);
   logic                  i_req_valid;
   logic                  i_req_ready;
   logic [ADDR_WIDTH-1:0] i_req_addr;
   logic                  i_rsp_valid;
   logic                  i_rsp_ready;
   logic [DATA_WIDTH-1:0] i_rsp_data;

   logic                  d_req_valid;
   logic                  d_req_ready;
   logic [ADDR_WIDTH-1:0] d_req_addr;
   logic [DATA_WIDTH-1:0] d_req_wdata;
   logic                  d_req_w_en;
   logic                  d_rsp_valid;
   logic                  d_rsp_ready;
   logic [DATA_WIDTH-1:0] d_rsp_data;

   logic                  m_req_valid;
   logic                  m_req_ready;
   logic [ADDR_WIDTH-1:0] m_addr;
   logic [DATA_WIDTH-1:0] m_wdata;
   logic                  m_w_en;
   logic                  m_rsp_valid;
   logic                  m_rsp_ready;
   logic [DATA_WIDTH-1:0] m_rdata;

   // Arbiter side.
   modport slave (
      input  i_req_valid, i_req_addr, i_rsp_ready,
      output i_req_ready, i_rsp_valid, i_rsp_data,
      input  d_req_valid, d_req_addr, d_req_wdata, d_req_w_en, d_rsp_ready,
      output d_req_ready, d_rsp_valid, d_rsp_data,
      output m_req_valid, m_addr, m_wdata, m_w_en, m_rsp_ready,
      input  m_req_ready, m_rsp_valid, m_rdata
   );

   // Requester / RAM side.
   modport master (
      output i_req_valid, i_req_addr, i_rsp_ready,
      input  i_req_ready, i_rsp_valid, i_rsp_data,
      output d_req_valid, d_req_addr, d_req_wdata, d_req_w_en, d_rsp_ready,
      input  d_req_ready, d_rsp_valid, d_rsp_data,
      input  m_req_valid, m_addr, m_wdata, m_w_en, m_rsp_ready,
      output m_req_ready, m_rsp_valid, m_rdata
   );
endinterface

// File: rtl/cprv_mem_arbiter.sv
// Two-requester arbiter (instruction fetch, data) in front of one single-port RAM.
// One transaction in flight at a time; ties alternate between the requesters.
module cprv_mem_arbiter #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 7
) (
   input  logic                clk,
   input  logic                rst,
   cprv_mem_arbiter_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RSP  = 2'd2
   } state_t;

   state_t                state;
   logic                  owner_d;
   logic                  last_d;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  w_en_q;

   logic                  grant_i;
   logic                  grant_d;
   logic                  owner_rsp_ready;

   // last_d set means data was granted last, so fetch wins the next tie.
   always_comb begin
      grant_i = (state == IDLE) && !rst && bus.i_req_valid &&
                (!bus.d_req_valid || last_d);
      grant_d = (state == IDLE) && !rst && bus.d_req_valid &&
                (!bus.i_req_valid || !last_d);
      owner_rsp_ready = owner_d ? bus.d_rsp_ready : bus.i_rsp_ready;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         owner_d <= 1'b0;
         last_d  <= 1'b1;
         addr_q  <= '0;
         wdata_q <= '0;
         w_en_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_i) begin
                  addr_q  <= bus.i_req_addr;
                  wdata_q <= '0;
                  w_en_q  <= 1'b0;
                  owner_d <= 1'b0;
                  last_d  <= 1'b0;
                  state   <= REQ;
               end else if (grant_d) begin
                  addr_q  <= bus.d_req_addr;
                  wdata_q <= bus.d_req_wdata;
                  w_en_q  <= bus.d_req_w_en;
                  owner_d <= 1'b1;
                  last_d  <= 1'b1;
                  state   <= REQ;
               end
            end
            REQ: begin
               if (bus.m_req_ready) state <= RSP;
            end
            RSP: begin
               if (bus.m_rsp_valid && owner_rsp_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.m_addr  = addr_q;
   assign bus.m_wdata = wdata_q;
   assign bus.m_w_en  = w_en_q;

   // Response path is a combinational pass-through steered by the owner.
   always_comb begin
      bus.i_req_ready = grant_i;
      bus.d_req_ready = grant_d;
      bus.m_req_valid = (state == REQ);
      bus.m_rsp_ready = (state == RSP) && owner_rsp_ready;
      bus.i_rsp_valid = (state == RSP) && !owner_d && bus.m_rsp_valid;
      bus.d_rsp_valid = (state == RSP) &&  owner_d && bus.m_rsp_valid;
      bus.i_rsp_data  = bus.m_rdata;
      bus.d_rsp_data  = bus.m_rdata;
   end

endmodule

// File: tb/tb_cprv_mem_arbiter.sv
// Scoreboard bench for cprv_mem_arbiter: directed stimulus pushes expected RAM
// requests and responses; a monitor pops and compares on every handshake.
module tb_cprv_mem_arbiter;
   localparam int DW = 64;
   localparam int AW = 7;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cprv_mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
   cprv_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic          w_en;
   } mreq_t;

   typedef struct {
      logic [DW-1:0] data;
      logic          care;
   } drsp_t;

   mreq_t         q_mreq [$];
   logic [DW-1:0] q_i    [$];
   drsp_t         q_d    [$];

   int checks   = 0;
   int failures = 0;

   logic [DW-1:0] mem [0:127];
   int            stall_req = 0;
   logic          flush     = 1'b0;
   logic          pend      = 1'b0;
   logic [DW-1:0] pend_data = '0;
   logic          hs_req    = 1'b0;
   logic          hs_rsp    = 1'b0;
   logic [AW-1:0] hs_addr   = '0;
   logic [DW-1:0] hs_wdata  = '0;
   logic          hs_wen    = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // RAM model: drives at negedge, records the handshakes the next posedge will see.
   initial begin
      bus.m_req_ready = 1'b0;
      bus.m_rsp_valid = 1'b0;
      bus.m_rdata     = '0;
      forever begin
         @(negedge clk);
         if (hs_req) begin
            pend      = 1'b1;
            pend_data = hs_wen ? '0 : mem[hs_addr];
            if (hs_wen) mem[hs_addr] = hs_wdata;
         end
         if (hs_rsp || flush) pend = 1'b0;
         if (bus.m_req_valid && stall_req > 0) begin
            stall_req--;
            bus.m_req_ready = 1'b0;
         end else begin
            bus.m_req_ready = bus.m_req_valid;
         end
         bus.m_rsp_valid = pend;
         bus.m_rdata     = pend ? pend_data : '0;
         #1;
         hs_req   = !rst && bus.m_req_valid && bus.m_req_ready;
         hs_addr  = bus.m_addr;
         hs_wdata = bus.m_wdata;
         hs_wen   = bus.m_w_en;
         hs_rsp   = !rst && bus.m_rsp_valid && bus.m_rsp_ready;
      end
   end

   // Monitor
   initial begin
      mreq_t         em;
      logic [DW-1:0] ei;
      drsp_t         ed;
      forever begin
         @(negedge clk);
         #2;
         if (!rst) begin
            chk("rsp_valid_exclusive", {63'd0, bus.i_rsp_valid & bus.d_rsp_valid}, 64'd0);
            if (bus.m_req_valid && bus.m_req_ready) begin
               if (q_mreq.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL m_req_unexpected: got addr 0x%0h, required none", bus.m_addr);
               end else begin
                  em = q_mreq.pop_front();
                  chk("m_addr", {57'd0, bus.m_addr}, {57'd0, em.addr});
                  chk("m_wdata", bus.m_wdata, em.wdata);
                  chk("m_w_en", {63'd0, bus.m_w_en}, {63'd0, em.w_en});
               end
            end
            if (bus.i_rsp_valid && bus.i_rsp_ready) begin
               if (q_i.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL i_rsp_unexpected: got 0x%0h, required none", bus.i_rsp_data);
               end else begin
                  ei = q_i.pop_front();
                  chk("i_rsp_data", bus.i_rsp_data, ei);
               end
            end
            if (bus.d_rsp_valid && q_d.size() == 0) begin
               checks++; failures++;
               $display("FAIL d_rsp_unexpected: got d_rsp_valid 1, required 0");
            end else if (bus.d_rsp_valid && bus.d_rsp_ready) begin
               ed = q_d.pop_front();
               if (ed.care) chk("d_rsp_data", bus.d_rsp_data, ed.data);
            end
         end
      end
   end

   task automatic req_i(input logic [AW-1:0] a);
      int n;
      @(negedge clk);
      bus.i_req_valid = 1'b1;
      bus.i_req_addr  = a;
      n = 0;
      #1;
      while (!bus.i_req_ready && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("i_grant_in_time", {63'd0, n < 100}, 64'd1);
      @(negedge clk);
      bus.i_req_valid = 1'b0;
   endtask

   task automatic req_d(input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic we);
      int n;
      @(negedge clk);
      bus.d_req_valid = 1'b1;
      bus.d_req_addr  = a;
      bus.d_req_wdata = wd;
      bus.d_req_w_en  = we;
      n = 0;
      #1;
      while (!bus.d_req_ready && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("d_grant_in_time", {63'd0, n < 100}, 64'd1);
      @(negedge clk);
      bus.d_req_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q_mreq.size() != 0 || q_i.size() != 0 || q_d.size() != 0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("drain_in_time", {63'd0, n < 200}, 64'd1);
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_i_rsp();
      int n;
      n = 0;
      #3;
      while (!bus.i_rsp_valid && n < 50) begin
         @(negedge clk);
         #3;
         n++;
      end
      chk("i_rsp_in_time", {63'd0, n < 50}, 64'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = '0;
      rst = 1'b1;
      bus.i_req_valid = 1'b0; bus.i_req_addr = '0; bus.i_rsp_ready = 1'b1;
      bus.d_req_valid = 1'b0; bus.d_req_addr = '0; bus.d_req_wdata = '0;
      bus.d_req_w_en  = 1'b0; bus.d_rsp_ready = 1'b1;

      // Reset state
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #3;
      chk("rst_i_req_ready", {63'd0, bus.i_req_ready}, 64'd0);
      chk("rst_d_req_ready", {63'd0, bus.d_req_ready}, 64'd0);
      chk("rst_m_req_valid", {63'd0, bus.m_req_valid}, 64'd0);
      chk("rst_m_rsp_ready", {63'd0, bus.m_rsp_ready}, 64'd0);
      chk("rst_i_rsp_valid", {63'd0, bus.i_rsp_valid}, 64'd0);
      chk("rst_d_rsp_valid", {63'd0, bus.d_rsp_valid}, 64'd0);
      chk("rst_m_addr", {57'd0, bus.m_addr}, 64'd0);
      chk("rst_m_wdata", bus.m_wdata, 64'd0);
      chk("rst_m_w_en", {63'd0, bus.m_w_en}, 64'd0);

      // Single fetch at 0x05, ready for exactly one cycle
      mem[7'h05] = 64'h0000_0000_0000_00AB;
      q_mreq.push_back('{7'h05, 64'd0, 1'b0});
      q_i.push_back(64'h0000_0000_0000_00AB);
      @(negedge clk);
      bus.i_req_valid = 1'b1;
      bus.i_req_addr  = 7'h05;
      #3;
      chk("t1_i_req_ready", {63'd0, bus.i_req_ready}, 64'd1);
      chk("t1_d_req_ready", {63'd0, bus.d_req_ready}, 64'd0);
      chk("t1_m_req_valid_idle", {63'd0, bus.m_req_valid}, 64'd0);
      @(negedge clk);
      #3;
      chk("t1_i_req_ready_once", {63'd0, bus.i_req_ready}, 64'd0);
      chk("t1_m_req_valid", {63'd0, bus.m_req_valid}, 64'd1);
      chk("t1_m_addr", {57'd0, bus.m_addr}, 64'h05);
      chk("t1_m_w_en", {63'd0, bus.m_w_en}, 64'd0);
      bus.i_req_valid = 1'b0;
      drain();

      // Ties after reset: I first, then D, then a renewed tie goes to D
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      mem[7'h0A] = 64'h0000_0000_0000_CAFE;
      mem[7'h10] = 64'h1234_5678_9ABC_DEF0;
      mem[7'h0B] = 64'h0000_0000_0000_BEEF;
      q_mreq.push_back('{7'h0A, 64'd0, 1'b0});
      q_mreq.push_back('{7'h10, 64'd0, 1'b0});
      q_mreq.push_back('{7'h0B, 64'd0, 1'b0});
      q_i.push_back(64'h0000_0000_0000_CAFE);
      q_i.push_back(64'h0000_0000_0000_BEEF);
      q_d.push_back('{64'h1234_5678_9ABC_DEF0, 1'b1});
      fork
         begin
            req_i(7'h0A);
            req_i(7'h0B);
         end
         req_d(7'h10, 64'd0, 1'b0);
      join
      drain();

      // Data write then read-back
      q_mreq.push_back('{7'h03, 64'h0000_0000_0000_DEAD, 1'b1});
      q_d.push_back('{64'd0, 1'b0});
      req_d(7'h03, 64'h0000_0000_0000_DEAD, 1'b1);
      drain();
      q_mreq.push_back('{7'h03, 64'd0, 1'b0});
      q_d.push_back('{64'h0000_0000_0000_DEAD, 1'b1});
      req_d(7'h03, 64'd0, 1'b0);
      drain();

      // Back-pressure on both RAM request and fetch response
      mem[7'h20] = 64'h0000_0000_0000_5555;
      q_mreq.push_back('{7'h20, 64'd0, 1'b0});
      q_i.push_back(64'h0000_0000_0000_5555);
      stall_req = 4;
      bus.i_rsp_ready = 1'b0;
      req_i(7'h20);
      for (int k = 0; k < 4; k++) begin
         #3;
         chk("t4_m_req_valid_held", {63'd0, bus.m_req_valid}, 64'd1);
         chk("t4_m_addr_held", {57'd0, bus.m_addr}, 64'h20);
         @(negedge clk);
      end
      wait_i_rsp();
      for (int k = 0; k < 3; k++) begin
         if (k > 0) begin
            @(negedge clk);
            #3;
         end
         chk("t4_i_rsp_valid_held", {63'd0, bus.i_rsp_valid}, 64'd1);
         chk("t4_i_rsp_data_held", bus.i_rsp_data, 64'h5555);
         chk("t4_m_rsp_ready_low", {63'd0, bus.m_rsp_ready}, 64'd0);
      end
      @(negedge clk);
      bus.i_rsp_ready = 1'b1;
      drain();

      // Reset while in RSP discards the transaction
      mem[7'h30] = 64'h0000_0000_0000_0077;
      q_mreq.push_back('{7'h30, 64'd0, 1'b0});
      bus.i_rsp_ready = 1'b0;
      req_i(7'h30);
      wait_i_rsp();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #3;
      chk("t5_i_rsp_valid", {63'd0, bus.i_rsp_valid}, 64'd0);
      chk("t5_d_rsp_valid", {63'd0, bus.d_rsp_valid}, 64'd0);
      chk("t5_m_req_valid", {63'd0, bus.m_req_valid}, 64'd0);
      chk("t5_m_rsp_ready", {63'd0, bus.m_rsp_ready}, 64'd0);
      chk("t5_m_addr", {57'd0, bus.m_addr}, 64'd0);
      bus.i_rsp_ready = 1'b1;
      #1;
      chk("t5_stray_rsp_ignored", {63'd0, bus.m_rsp_ready}, 64'd0);
      chk("t5_stray_no_i_rsp", {63'd0, bus.i_rsp_valid}, 64'd0);
      flush = 1'b1;
      @(negedge clk);
      #3;
      flush = 1'b0;
      mem[7'h07] = 64'h0707_0707_0707_0707;
      q_mreq.push_back('{7'h07, 64'd0, 1'b0});
      q_i.push_back(64'h0707_0707_0707_0707);
      req_i(7'h07);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cprv_mem_arbiter.md
CPRV_MEM_ARBITER -- requirements
Module: cprv_mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 64, SHALL set the data width of every data/wdata/rdata port.
REQ-002 Parameter ADDR_WIDTH, default 7, SHALL set the width of every address port.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  SHALL be the synchronous, active-high reset.
REQ-005 i_req_valid  in  1  instruction-fetch request valid.
REQ-006 i_req_ready  out  1  instruction request accepted this cycle.
REQ-007 i_req_addr  in  ADDR_WIDTH  fetch address.
REQ-008 i_rsp_valid  out  1  fetch response valid.
REQ-009 i_rsp_ready  in  1  fetch requester can take the response.
REQ-010 i_rsp_data  out  DATA_WIDTH  fetch response data.
REQ-011 d_req_valid  in  1  data-port request valid.
REQ-012 d_req_ready  out  1  data request accepted this cycle.
REQ-013 d_req_addr  in  ADDR_WIDTH  data address.
REQ-014 d_req_wdata  in  DATA_WIDTH  write data.
REQ-015 d_req_w_en  in  1  1 = write, 0 = read.
REQ-016 d_rsp_valid  out  1  data response valid.
REQ-017 d_rsp_ready  in  1  data requester can take the response.
REQ-018 d_rsp_data  out  DATA_WIDTH  data response (read data; don't-care for writes).
REQ-019 m_req_valid  out  1  request to shared single-port RAM valid.
REQ-020 m_req_ready  in  1  RAM accepts request.
REQ-021 m_addr / m_wdata / m_w_en  out  ADDR_WIDTH / DATA_WIDTH / 1  RAM request fields.
REQ-022 m_rsp_valid  in  1  RAM response valid (one per accepted request, reads and writes).
REQ-023 m_rsp_ready  out  1  arbiter accepts RAM response.
REQ-024 m_rdata  in  DATA_WIDTH  RAM response data.

Function
REQ-025 The block SHALL hold at most one outstanding transaction, sequenced by FSM states IDLE, REQ, RSP.
REQ-026 IDLE: if any req_valid, grant one requester, assert its req_ready for exactly that cycle, register addr/wdata/w_en (I-port w_en forced 0), record owner, go to REQ.
REQ-027 Arbitration: single valid wins; both valid -> requester not granted last wins; last_grant updates on every grant.
REQ-028 REQ: m_req_valid=1 with registered fields held stable until m_req_valid&m_req_ready, then go to RSP.
REQ-029 RSP: owner rsp_valid=m_rsp_valid, owner rsp_data=m_rdata (combinational pass-through), m_rsp_ready=owner rsp_ready; on m_rsp_valid&m_rsp_ready go to IDLE.
REQ-030 Non-owner rsp_valid, both req_ready outside IDLE, m_req_valid outside REQ, m_rsp_ready outside RSP SHALL be 0.
REQ-031 Minimum transaction occupancy SHALL be 3 cycles (accept, RAM request, response); a new request can be accepted the cycle after the response handshake.
REQ-032 m_rsp_valid arriving outside RSP SHALL be ignored (not acknowledged).

Reset
REQ-033 rst=1 SHALL force state IDLE, all valid/ready outputs 0, m_addr/m_wdata/m_w_en 0, owner=I, last_grant=D (I wins first tie), in the following cycle, even mid-transaction; the in-flight transaction is discarded.

Verification
REQ-034 I fetch addr 0x05 -> i_req_ready 1 cycle, next cycle m_req_valid, m_addr 0x05, m_w_en 0; m_rdata 0x00000000000000AB routed to i_rsp_data; d_rsp_valid stays 0.
REQ-035 I and D valid together after reset (D addr 0x10) -> I served first, D served next; a second tie -> D wins.
REQ-036 D write addr 0x03, wdata 0xDEAD, w_en 1 -> m_w_en 1, m_wdata 0xDEAD; response handshake on d port returns FSM to IDLE.
REQ-037 m_req_ready low 4 cycles -> m_req_valid, m_addr held; i_rsp_ready low 3 cycles -> m_rsp_ready low, i_rsp_valid/data held.
REQ-038 rst pulse while in RSP -> next cycle all valids 0, IDLE; subsequent fetch addr 0x07 completes normally.
